pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Control bundle between the pipeline hazard/redirect sources and pipe_ctrl.
//   master : the requesting side, which drives load_stall, flush and br_target
//            and observes the pipeline enables, bubbles, redirect and counters.
//   slave  : pipe_ctrl itself.
interface pipe_ctrl_if;
  logic        load_stall;
  logic        flush;
  logic [31:0] br_target;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pc_redirect;
  logic [31:0] pc_redirect_addr;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        stall_timeout;

  modport master (
    output load_stall, flush, br_target,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, pc_redirect,
           pc_redirect_addr, stall_cnt, flush_cnt, stall_timeout
  );

  modport slave (
    input  load_stall, flush, br_target,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, pc_redirect,
           pc_redirect_addr, stall_cnt, flush_cnt, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline stall/flush controller. Each cycle it arbitrates between a
//   branch/jump redirect (flush), a load-use stall (load_stall) and normal
//   advance. It produces the PC and IF/ID write enables and the bubble
//   controls for IF/ID and ID/EX. It also keeps saturating event counters
//   and a sticky watchdog that trips on a run of consecutive stalls.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : pipe_ctrl_if.slave
//          in  : load_stall, flush, br_target
//          out : pc_en, if_id_en, if_id_flush, id_ex_flush, pc_redirect,
//                pc_redirect_addr, stall_cnt, flush_cnt, stall_timeout
//
// State  | meaning
// -------+-----------------------------------------------------------------
// RUN    | normal advance
// STALL  | previous cycle was a load-use stall
// FLUSH  | IF/ID still being killed after a redirect; fl_cnt cycles remain
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_MAX    = 16
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIMIT  = 8'(STALL_MAX);
  // With a single-cycle flush the acceptance cycle covers everything.
  localparam state_t     FLUSH_NEXT   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t      state, state_nxt;
  logic [2:0]  fl_cnt, fl_cnt_nxt;
  logic [7:0]  run_cnt;
  logic [7:0]  run_inc;
  logic        accept_flush;
  logic        accept_stall;

  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pc_redirect;
  logic [31:0] pc_redirect_addr;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        stall_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      fl_cnt <= 3'd0;
    end else begin
      state  <= state_nxt;
      fl_cnt <= fl_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fl_cnt_nxt   = fl_cnt;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pc_redirect  = 1'b0;
    accept_flush = 1'b0;
    accept_stall = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = RUN;
      fl_cnt_nxt  = 3'd0;
    end else if (bus.flush) begin
      // A redirect in FLUSH restarts the kill window rather than extending it.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      pc_redirect  = 1'b1;
      accept_flush = 1'b1;
      fl_cnt_nxt   = FLUSH_RELOAD;
      state_nxt    = FLUSH_NEXT;
    end else if (bus.load_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
      accept_stall = 1'b1;
      // A stall during FLUSH freezes the kill window; IF/ID keeps its bubble.
      if (state == FLUSH) begin
        if_id_flush = 1'b1;
      end else begin
        state_nxt = STALL;
      end
    end else begin
      case (state)
        FLUSH: begin
          if_id_flush = 1'b1;
          if (fl_cnt <= 3'd1) begin
            fl_cnt_nxt = 3'd0;
            state_nxt  = RUN;
          end else begin
            fl_cnt_nxt = fl_cnt - 3'd1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign run_inc = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt          <= 8'd0;
      stall_cnt        <= 32'd0;
      flush_cnt        <= 32'd0;
      pc_redirect_addr <= 32'd0;
      stall_timeout    <= 1'b0;
    end else begin
      if (accept_flush) begin
        pc_redirect_addr <= bus.br_target;
        if (flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
      end
      // Any cycle that is not an honoured stall breaks the consecutive run.
      if (accept_stall) begin
        run_cnt <= run_inc;
        if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
        if (run_inc >= STALL_LIMIT) stall_timeout <= 1'b1;
      end else begin
        run_cnt <= 8'd0;
      end
    end
  end

  assign bus.pc_en            = pc_en;
  assign bus.if_id_en         = if_id_en;
  assign bus.if_id_flush      = if_id_flush;
  assign bus.id_ex_flush      = id_ex_flush;
  assign bus.pc_redirect      = pc_redirect;
  assign bus.pc_redirect_addr = pc_redirect_addr;
  assign bus.stall_cnt        = stall_cnt;
  assign bus.flush_cnt        = flush_cnt;
  assign bus.stall_timeout    = stall_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl (FLUSH_CYCLES=2, STALL_MAX=16). Each stimulus
//   cycle pushes its hand-computed expected outputs into a queue; a monitor
//   pops one entry per cycle on the falling edge and compares.
//   Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_flush, pc_redirect}.
//   Counter/address/timeout values are those registered before the cycle's edge.
module tb_pipe_ctrl;

  typedef struct {
    int          id;
    logic [4:0]  ctrl;
    logic [31:0] scnt;
    logic [31:0] fcnt;
    logic [31:0] addr;
    logic        tout;
  } exp_t;

  localparam logic [4:0] C_RUN  = 5'b11000;
  localparam logic [4:0] C_FL0  = 5'b11111;
  localparam logic [4:0] C_FL1  = 5'b11100;
  localparam logic [4:0] C_STL  = 5'b00010;
  localparam logic [4:0] C_STLF = 5'b00110;
  localparam logic [4:0] C_RST  = 5'b00110;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   vec_id;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] got;
      e = exp_q.pop_front();
      got = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.pc_redirect};
      n_cmp = n_cmp + 1;
      if (got !== e.ctrl || bus.stall_cnt !== e.scnt || bus.flush_cnt !== e.fcnt ||
          bus.pc_redirect_addr !== e.addr || bus.stall_timeout !== e.tout) begin
        n_bad = n_bad + 1;
        $display("FAIL vec%0d: got ctrl=%b scnt=%0d fcnt=%0d addr=%h tout=%b ; exp ctrl=%b scnt=%0d fcnt=%0d addr=%h tout=%b",
                 e.id, got, bus.stall_cnt, bus.flush_cnt, bus.pc_redirect_addr, bus.stall_timeout,
                 e.ctrl, e.scnt, e.fcnt, e.addr, e.tout);
      end
    end
  end

  task automatic step(input logic r, input logic ls, input logic fl, input logic [31:0] tgt,
                      input logic [4:0] ectrl, input logic [31:0] escnt, input logic [31:0] efcnt,
                      input logic [31:0] eaddr, input logic etout);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    bus.load_stall = ls;
    bus.flush      = fl;
    bus.br_target  = tgt;
    e.id   = vec_id;
    e.ctrl = ectrl;
    e.scnt = escnt;
    e.fcnt = efcnt;
    e.addr = eaddr;
    e.tout = etout;
    exp_q.push_back(e);
    vec_id = vec_id + 1;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    vec_id         = 0;
    rst            = 1'b1;
    bus.load_stall = 1'b0;
    bus.flush      = 1'b0;
    bus.br_target  = 32'd0;
    repeat (2) @(posedge clk);

    // reset overrides requests
    step(1, 1, 1, 32'hDEAD, C_RST, 0, 0, 0, 0);
    // idle after reset
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, C_RUN, 0, 0, 0, 0);

    // single redirect, two-cycle kill
    step(0, 0, 1, 32'h400, C_FL0, 0, 0, 0, 0);
    step(0, 0, 0, 0,       C_FL1, 0, 1, 32'h400, 0);
    step(0, 0, 0, 0,       C_RUN, 0, 1, 32'h400, 0);

    // three stalls
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, C_STL, i, 1, 32'h400, 0);
    step(0, 0, 0, 0, C_RUN, 3, 1, 32'h400, 0);

    // stall and flush together: flush wins
    step(0, 1, 1, 32'h800, C_FL0, 3, 1, 32'h400, 0);
    // stall during FLUSH freezes the window
    step(0, 1, 0, 0, C_STLF, 3, 2, 32'h800, 0);
    step(0, 0, 0, 0, C_FL1,  4, 2, 32'h800, 0);
    step(0, 0, 0, 0, C_RUN,  4, 2, 32'h800, 0);

    // flush inside FLUSH restarts the window
    step(0, 0, 1, 32'hC00,  C_FL0, 4, 2, 32'h800, 0);
    step(0, 0, 1, 32'h1000, C_FL0, 4, 3, 32'hC00, 0);
    step(0, 0, 0, 0,        C_FL1, 4, 4, 32'h1000, 0);
    step(0, 0, 0, 0,        C_RUN, 4, 4, 32'h1000, 0);

    // 15 consecutive stalls: one short of the watchdog
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, C_STL, 4 + i, 4, 32'h1000, 0);
    step(0, 0, 0, 0, C_RUN, 19, 4, 32'h1000, 0);

    // 16 consecutive stalls: watchdog trips and stays set
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, C_STL, 19 + i, 4, 32'h1000, 0);
    step(0, 0, 0, 0, C_RUN, 35, 4, 32'h1000, 1);
    step(0, 0, 0, 0, C_RUN, 35, 4, 32'h1000, 1);

    // reset during FLUSH cycle 1
    step(0, 0, 1, 32'h40, C_FL0, 35, 4, 32'h1000, 1);
    step(1, 0, 0, 0,      C_RST, 35, 5, 32'h40,   1);
    step(0, 0, 0, 0,      C_RUN, 0, 0, 0, 0);

    // reset during STALL
    step(0, 1, 0, 0,      C_STL, 0, 0, 0, 0);
    step(1, 1, 1, 32'h99, C_RST, 1, 0, 0, 0);
    step(0, 0, 0, 0,      C_RUN, 0, 0, 0, 0);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
